// File: rtl/doorbell_pkg.sv
// Shared types and tone patterns for the doorbell chime sequencer.
// In each pattern, bit[step] gives the value of sel (0 = ding, 1 = dong).
package doorbell_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef enum logic {
    SRC_FRONT = 1'b0,
    SRC_BACK  = 1'b1
  } src_e;

  localparam logic [1:0] FRONT_PAT   = 2'b10;
  localparam int         FRONT_STEPS = 2;
  localparam logic [2:0] BACK_PAT    = 3'b111;
  localparam int         BACK_STEPS  = 3;

  function automatic logic pat_bit(input src_e src, input logic [1:0] step);
    logic [2:0] pat;
    pat = (src == SRC_BACK) ? BACK_PAT : {1'b0, FRONT_PAT};
    case (step)
      2'd0:    return pat[0];
      2'd1:    return pat[1];
      default: return pat[2];
    endcase
  endfunction

  function automatic logic [1:0] last_step(input src_e src);
    return (src == SRC_BACK) ? 2'(BACK_STEPS - 1) : 2'(FRONT_STEPS - 1);
  endfunction

endpackage

// File: rtl/doorbell_sequencer_if.sv
// Button inputs and chime outputs of the doorbell sequencer.
interface doorbell_sequencer_if;
  logic btn_front;
  logic btn_back;
  logic sel;
  logic tone_en;
  logic busy;
  logic active_src;

  modport master (output btn_front, btn_back, input sel, tone_en, busy, active_src);
  modport slave  (input btn_front, btn_back, output sel, tone_en, busy, active_src);
endinterface

// File: rtl/doorbell_edge_det.sv
// Rising-edge press detector; a held button yields a single press.
module doorbell_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  logic btn_q;

  // btn_q clears in reset so a button held across reset release reads as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= btn;
  end

  assign press = btn & ~btn_q;
endmodule

// File: rtl/doorbell_sequencer.sv
// Two-source chime controller: one-deep request queue per button, round-robin
// grant, and a tone/gap sequencer that drives the doorbell mux select.
module doorbell_sequencer
  import doorbell_pkg::*;
#(
  parameter int TONE_LEN = 8,
  parameter int GAP_LEN  = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  doorbell_sequencer_if.slave  bus
);
  localparam int MAX_LEN = (TONE_LEN > GAP_LEN) ? TONE_LEN : GAP_LEN;
  localparam int CNT_W   = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);

  logic             press_f, press_b;
  logic [1:0]       pend;
  logic             grant;
  src_e             grant_src, last_src, act_r;
  state_e           state;
  logic [1:0]       step;
  logic [CNT_W-1:0] cnt;
  logic             sel_r, tone_r, busy_r;

  doorbell_edge_det u_det_front (.clk(clk), .rst_n(rst_n), .btn(bus.btn_front), .press(press_f));
  doorbell_edge_det u_det_back  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_back),  .press(press_b));

  // On a tie, the source that was not served last wins
  always_comb begin
    grant     = (state == IDLE) && (pend != 2'b00);
    grant_src = SRC_FRONT;
    if (pend == 2'b11)
      grant_src = (last_src == SRC_BACK) ? SRC_FRONT : SRC_BACK;
    else if (pend[1])
      grant_src = SRC_BACK;
  end

  // A press on the grant edge re-arms the bit, so set wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 2'b00;
    end else begin
      pend[0] <= press_f | (pend[0] & ~(grant && grant_src == SRC_FRONT));
      pend[1] <= press_b | (pend[1] & ~(grant && grant_src == SRC_BACK));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step     <= 2'd0;
      cnt      <= '0;
      sel_r    <= 1'b0;
      tone_r   <= 1'b0;
      busy_r   <= 1'b0;
      act_r    <= SRC_FRONT;
      last_src <= SRC_BACK;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= TONE;
            step     <= 2'd0;
            cnt      <= TONE_LOAD;
            act_r    <= grant_src;
            last_src <= grant_src;
            sel_r    <= pat_bit(grant_src, 2'd0);
            tone_r   <= 1'b1;
            busy_r   <= 1'b1;
          end
        end
        TONE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (step == last_step(act_r)) begin
            state  <= IDLE;
            tone_r <= 1'b0;
            busy_r <= 1'b0;
          end else begin
            state  <= GAP;
            cnt    <= GAP_LOAD;
            tone_r <= 1'b0;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state  <= TONE;
            step   <= step + 2'd1;
            cnt    <= TONE_LOAD;
            sel_r  <= pat_bit(act_r, step + 2'd1);
            tone_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel        = sel_r;
  assign bus.tone_en    = tone_r;
  assign bus.busy       = busy_r;
  assign bus.active_src = act_r;
endmodule

// File: tb/tb_doorbell_sequencer.sv
// Bench for doorbell_sequencer: directed scenarios plus random button traffic,
// checked every cycle against a chime-timeline reference model.
module tb_doorbell_sequencer;
  localparam int TONE_LEN = 4;
  localparam int GAP_LEN  = 2;

  typedef struct packed {
    logic tone;
    logic sel;
    logic busy;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  doorbell_sequencer_if ifc ();

  doorbell_sequencer #(.TONE_LEN(TONE_LEN), .GAP_LEN(GAP_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: per-source request bits plus a queue of the outputs
  // expected after each upcoming edge for the chime in progress.
  logic [1:0] m_pend, m_bq;
  logic       m_last, m_src, m_tone, m_sel, m_busy;
  ent_t       exp_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_all();
    chk_eq("tone_en",    32'(ifc.tone_en),    32'(m_tone));
    chk_eq("sel",        32'(ifc.sel),        32'(m_sel));
    chk_eq("busy",       32'(ifc.busy),       32'(m_busy));
    chk_eq("active_src", 32'(ifc.active_src), 32'(m_src));
  endtask

  task automatic model_reset();
    m_pend = 2'b00; m_bq = 2'b00; m_last = 1'b1; m_src = 1'b0;
    m_tone = 1'b0;  m_sel = 1'b0; m_busy = 1'b0;
    exp_q.delete();
  endtask

  // Front plays ding,dong; back plays dong,dong,dong
  task automatic build_chime(input logic src);
    int   n;
    logic tones[3];
    if (src) begin n = 3; tones[0] = 1'b1; tones[1] = 1'b1; tones[2] = 1'b1; end
    else     begin n = 2; tones[0] = 1'b0; tones[1] = 1'b1; tones[2] = 1'b0; end
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < TONE_LEN; i++) exp_q.push_back('{tone: 1'b1, sel: tones[s], busy: 1'b1});
      if (s != n - 1)
        for (int i = 0; i < GAP_LEN; i++) exp_q.push_back('{tone: 1'b0, sel: tones[s], busy: 1'b1});
    end
    exp_q.push_back('{tone: 1'b0, sel: tones[n-1], busy: 1'b0});
  endtask

  task automatic model_edge(input logic bf, input logic bb);
    logic [1:0] pr;
    logic       g;
    ent_t       e;
    pr   = {bb, bf} & ~m_bq;
    m_bq = {bb, bf};
    if (exp_q.size() == 0 && m_pend != 2'b00) begin
      g = (m_pend == 2'b11) ? ~m_last : m_pend[1];
      m_pend[g] = 1'b0;
      m_last = g;
      m_src  = g;
      build_chime(g);
    end
    m_pend = m_pend | pr;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_tone = e.tone; m_sel = e.sel; m_busy = e.busy;
    end else begin
      m_tone = 1'b0; m_busy = 1'b0;
    end
  endtask

  // Called at a negedge: drive buttons, advance one edge, check at the next negedge
  task automatic step(input logic bf, input logic bb);
    ifc.btn_front = bf;
    ifc.btn_back  = bb;
    @(posedge clk);
    model_edge(bf, bb);
    @(negedge clk);
    cyc++;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all();
    rst_n = 1'b1;
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_eq("rst_async_tone", 32'(ifc.tone_en), 32'(0));
    chk_eq("rst_async_busy", 32'(ifc.busy),    32'(0));
    chk_eq("rst_async_sel",  32'(ifc.sel),     32'(0));
    @(negedge clk);
    chk_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bf, bb;
    ifc.btn_front = 1'b0;
    ifc.btn_back  = 1'b0;
    model_reset();
    do_reset();
    idle(10);

    step(1'b1, 1'b0); idle(14);
    step(1'b0, 1'b1); idle(20);
    step(1'b1, 1'b1); idle(30);
    step(1'b1, 1'b1); idle(30);

    for (int i = 0; i < 30; i++) step((i == 4 || i == 6 || i == 8) ? 1'b0 : 1'b1, 1'b0);
    idle(30);

    step(1'b1, 1'b0); idle(6);
    mid_reset();
    idle(10);

    ifc.btn_front = 1'b1;
    do_reset();
    step(1'b1, 1'b0); step(1'b1, 1'b0); idle(14);

    bf = 1'b0; bb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) bf = ~bf;
      if ($urandom_range(0, 5) == 0) bb = ~bb;
      if ($urandom_range(0, 399) == 0) mid_reset();
      else step(bf, bb);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/doorbell_sequencer.md
# doorbell_sequencer

Synchronous chime controller that drives the select line of the `doorbell` two-sound multiplexer. It accepts presses from two bell buttons (front and back), queues one request per button and arbitrates round-robin. It plays a fixed tone pattern per source by sequencing `sel` and a tone enable. It sits between the button inputs and the `doorbell` mux; the mux itself is instantiated at the integration level, not inside this block.

## Interface
- `TONE_LEN`, default 8: cycles each tone is sounded; legal range ≥ 1.
- `GAP_LEN`, default 2: silent cycles between tones within one chime; legal range ≥ 1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_front`  in  1  front button level, already synchronous to `clk`.
- `btn_back`  in  1  back button level, already synchronous to `clk`.
- `sel`  out  1  mux select: 0 = sound a ("ding"), 1 = sound b ("dong"); registered.
- `tone_en`  out  1  1 while a tone is sounding, 0 in gaps and idle; registered.
- `busy`  out  1  1 while a chime is in progress (TONE or GAP state).
- `active_src`  out  1  source being served: 0 = front, 1 = back; holds its last value when idle.

## Operation
- Press detect: a press is `btn & ~btn_q`, where `btn_q` is the previous sample. A held button is one press only.
- Pending bits: there is one per source, set by a press and cleared when that source is granted. A press arriving while the bit is already set is dropped, so the queue is one deep. If a set and a clear occur on the same edge for the same source, the set wins.
- FSM states are IDLE, TONE and GAP, with step index `step` (0..2) and cycle counter `cnt`.
  - IDLE: if any pending bit is set, grant, load `step=0`, load `cnt=TONE_LEN-1` and go to TONE.
  - TONE: `tone_en=1` and `sel`=pattern[step]. When `cnt==0`, go to GAP if `step` is not the last step, otherwise go to IDLE.
  - GAP: `tone_en=0` and `sel` holds. When `cnt==0`, increment `step` and go to TONE.
- Patterns:
  - Front: a, b. Two steps; chime length is 2·TONE_LEN+GAP_LEN.
  - Back: b, b, b. Three steps; chime length is 3·TONE_LEN+2·GAP_LEN.
- Arbitration:
  - If only one source is pending, it is granted.
  - If both are pending, the source not served last is granted.
  - The pointer resets to "last = back", so front wins the first tie.
- No preemption: a chime always completes. Presses during a chime only set pending bits.
- Counter width is `$clog2(max(TONE_LEN,GAP_LEN))` with a minimum of 1 bit. `cnt` decrements and never wraps below 0.

## Timing
- Reset (asynchronous, immediate) sets:
  - `sel=0`, `tone_en=0`, `busy=0`, `active_src=0`.
  - Both pending bits 0, `btn_q=0`, FSM in IDLE, round-robin pointer = back.
- Latency:
  - The button is first sampled high at edge k, so the pending bit is set after edge k.
  - The grant happens at edge k+1, so `tone_en`, `busy` and `sel`/`active_src` take their new values after edge k+1.
  - Press-to-sound latency is therefore 2 cycles.
- `tone_en` is high for exactly TONE_LEN consecutive cycles per tone, and low for exactly GAP_LEN cycles between tones.
- After the last tone, the FSM is in IDLE for at least 1 cycle (`busy=0`, `tone_en=0`) before the next grant.
- Back-to-back service: a request pending at the end of a chime starts its chime 1 cycle after `busy` falls.
- A button held high across reset deassertion counts as a press, because `btn_q` resets to 0.
- If reset asserts mid-chime, outputs go to their reset values immediately and queued requests are discarded.

## Structure
- Shared package `doorbell_pkg` holds:
  - A state enum (IDLE, TONE, GAP).
  - A source enum (SRC_FRONT=0, SRC_BACK=1).
  - Pattern constants: FRONT_PAT=2'b10 with FRONT_STEPS=2, and BACK_PAT=3'b111 with BACK_STEPS=3; bit[step] = `sel`.
- One sub-module: `doorbell_edge_det` (registered press detector with asynchronous active-low reset), instantiated once per button.
- The arbiter, FSM and counter live in the top module.

## Test plan
All scenarios use TONE_LEN=4 and GAP_LEN=2.
1. Reset with buttons low, then release reset → all outputs 0 and `busy=0` for 10 idle cycles.
2. Front pulse sampled at edge 0:
   - `tone_en=1`, `sel=0` in cycles 2–5.
   - `tone_en=0` in cycles 6–7.
   - `tone_en=1`, `sel=1` in cycles 8–11.
   - `busy=0` from cycle 12; `active_src=0` throughout.
3. Back pulse → three 4-cycle `sel=1` tones separated by 2-cycle gaps, `busy` high for 16 cycles, `active_src=1`.
4. Both buttons pressed on the same edge after reset → front chime first (10 cycles), 1 idle cycle, then back chime (16 cycles). Repeating with both buttons pressed again serves front first, because the last source served was back.
5. Front button held for 30 cycles, plus 3 extra front pulses during its chime → exactly 2 front chimes in total (the original plus one queued); no third chime.
6. Assert `rst_n` low during cycle 7 of a front chime → `tone_en`, `busy` and `sel` go to 0 within the same cycle; no chime after release unless a new press occurs.
